// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S types and word-select encoding
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } i2s_rx_state_t;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_sync.sv
// rtl/i2s_rx_sync.sv - 2-FF synchronizers for tclk/ws/td plus registered tclk rise detect
module i2s_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tclk,
    input  logic i_ws,
    input  logic i_td,
    output logic o_rise,
    output logic o_ws_s,
    output logic o_td_s
);

    logic [2:0] r_tclk;
    logic [1:0] r_ws;
    logic [1:0] r_td;
    logic       r_rise;
    logic       r_ws_s;
    logic       r_td_s;

    // ws/td are re-registered alongside rise so they stay aligned with it
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tclk <= '0;
            r_ws   <= '0;
            r_td   <= '0;
            r_rise <= 1'b0;
            r_ws_s <= 1'b0;
            r_td_s <= 1'b0;
        end else begin
            r_tclk <= {r_tclk[1:0], i_tclk};
            r_ws   <= {r_ws[0], i_ws};
            r_td   <= {r_td[0], i_td};
            r_rise <= r_tclk[1] & ~r_tclk[2];
            r_ws_s <= r_ws[1];
            r_td_s <= r_td[1];
        end
    end

    assign o_rise = r_rise;
    assign o_ws_s = r_ws_s;
    assign o_td_s = r_td_s;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receive engine: frame sync, deserialiser, valid/ready frame output
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_tclk,
    input  logic                  i_ws,
    input  logic                  i_td,
    output logic [DATA_WIDTH-1:0] o_data_left,
    output logic [DATA_WIDTH-1:0] o_data_right,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_overrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);

    logic w_rise;
    logic w_ws;
    logic w_td;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_shift_next;

    i2s_rx_state_t         r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_ws_prev;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic [DATA_WIDTH-1:0] r_data_left;
    logic [DATA_WIDTH-1:0] r_data_right;
    logic                  r_valid;
    logic                  r_overrun;

    i2s_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_tclk  (i_tclk),
        .i_ws    (i_ws),
        .i_td    (i_td),
        .o_rise  (w_rise),
        .o_ws_s  (w_ws),
        .o_td_s  (w_td)
    );

    // once cnt saturates the mask shifts out to zero, so extra bits of a long word drop
    assign w_mask = MSB_MASK >> r_cnt;

    always_comb begin
        w_shift_next = w_td ? (r_shift | w_mask) : (r_shift & ~w_mask);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_enable) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_ws_prev    <= WS_LEFT;
            r_left_hold  <= '0;
            r_data_left  <= '0;
            r_data_right <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && i_ready)
                r_valid <= 1'b0;
            unique case (r_state)
                IDLE: r_state <= SYNC;
                SYNC: begin
                    if (w_rise) begin
                        r_ws_prev <= w_ws;
                        if (w_ws == WS_LEFT && r_ws_prev == WS_RIGHT)
                            r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_rise) begin
                        r_ws_prev <= w_ws;
                        if (w_ws != r_ws_prev) begin
                            if (r_ws_prev == WS_LEFT) begin
                                r_left_hold <= w_shift_next;
                            end else begin
                                r_data_left  <= r_left_hold;
                                r_data_right <= w_shift_next;
                                r_valid      <= 1'b1;
                                r_overrun    <= r_valid & ~i_ready;
                            end
                            r_shift <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_shift <= w_shift_next;
                            if (r_cnt != CNT_MAX)
                                r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_data_left  = r_data_left;
    assign o_data_right = r_data_right;
    assign o_valid      = r_valid;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - self-checking bench for i2s_rx with a bit-level transmitter model
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        i_rst_n, i_enable, i_tclk, i_ws, i_td, i_ready;
    logic [31:0] o_data_left, o_data_right;
    logic        o_valid, o_overrun;

    always #5 clk = ~clk;

    i2s_rx #(.DATA_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .i_tclk       (i_tclk),
        .i_ws         (i_ws),
        .i_td         (i_td),
        .o_data_left  (o_data_left),
        .o_data_right (o_data_right),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_overrun    (o_overrun)
    );

    typedef struct {
        int          nbits;
        logic [63:0] l;
        logic [63:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;

    vec_t        tbl[6];
    int          n_vec = 0;
    int          n_err = 0;
    int          half = 4;
    int          ovr_cnt = 0;
    logic [31:0] got_l[$];
    logic [31:0] got_r[$];

    always @(negedge clk) begin
        if (i_rst_n) begin
            if (o_valid && i_ready) begin
                got_l.push_back(o_data_left);
                got_r.push_back(o_data_right);
            end
            if (o_overrun)
                ovr_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one tclk period: ws/td change while tclk low, receiver samples on the rise
    task automatic slot(input logic ws, input logic td);
        i_ws = ws;
        i_td = td;
        repeat (half) @(posedge clk);
        #1 i_tclk = 1'b1;
        repeat (half) @(posedge clk);
        #1 i_tclk = 1'b0;
    endtask

    // Philips alignment: the LSB slot already carries the next channel's ws
    task automatic send_word(input logic ch, input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 1; i--)
            slot(ch, v[i]);
        slot(~ch, v[0]);
    endtask

    task automatic check_frame(input string name, input logic [31:0] el, input logic [31:0] er);
        int t;
        t = 0;
        while (got_l.size() == 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        #1;
        n_vec++;
        if (got_l.size() == 0) begin
            n_err++;
            $display("FAIL %s_timeout: got no frame expected one within %0d cycles", name, t);
        end else begin
            chk({name, "_left"}, got_l.pop_front(), el);
            chk({name, "_right"}, got_r.pop_front(), er);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [63:0] v, input int n);
        logic [63:0] m;
        m = v & ((64'd1 << n) - 64'd1);
        if (n >= 32)
            return 32'(m >> (n - 32));
        return 32'(m << (32 - n));
    endfunction

    task automatic chk_outputs_clear(input string name);
        chk({name, "_valid"}, 32'(o_valid), 32'd0);
        chk({name, "_left"}, o_data_left, 32'd0);
        chk({name, "_right"}, o_data_right, 32'd0);
        chk({name, "_overrun"}, 32'(o_overrun), 32'd0);
    endtask

    task automatic interrupted_frame(input string name, input logic use_reset);
        logic [63:0] rw;
        rw = 64'h9876_5432;
        i_ready = 1'b0;
        send_word(1'b0, 64'h0F0F_0F0F, 32);
        send_word(1'b1, 64'hF0F0_F0F0, 32);
        send_word(1'b0, 64'h1234_5678, 32);
        for (int i = 31; i >= 16; i--)
            slot(1'b1, rw[i]);
        if (use_reset) i_rst_n = 1'b0;
        else           i_enable = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs_clear(name);
        i_rst_n  = 1'b1;
        i_enable = 1'b1;
        i_ready  = 1'b1;
        got_l.delete();
        got_r.delete();
        for (int i = 15; i >= 1; i--)
            slot(1'b1, rw[i]);
        slot(1'b0, rw[0]);
        send_word(1'b0, 64'h600D_0001, 32);
        send_word(1'b1, 64'h600D_0002, 32);
        check_frame({name, "_resync"}, 32'h600D_0001, 32'h600D_0002);
    endtask

    initial begin
        logic [63:0] lv, rv;
        int          n, ovr0;

        i_rst_n = 1'b0; i_enable = 1'b0; i_tclk = 1'b0;
        i_ws = 1'b0; i_td = 1'b0; i_ready = 1'b1;

        tbl[0] = '{32, 64'hA5A5_0001, 64'h5A5A_0002, 32'hA5A5_0001, 32'h5A5A_0002};
        tbl[1] = '{32, 64'hA5A5_0001, 64'h5A5A_0002, 32'hA5A5_0001, 32'h5A5A_0002};
        tbl[2] = '{24, 64'hAB_CDEF, 64'h12_3456, 32'hABCD_EF00, 32'h1234_5600};
        tbl[3] = '{40, 64'h12_3456_789A, 64'hFE_DCBA_9876, 32'h1234_5678, 32'hFEDC_BA98};
        tbl[4] = '{8, 64'hC3, 64'h3C, 32'hC300_0000, 32'h3C00_0000};
        tbl[5] = '{32, 64'hFFFF_FFFF, 64'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};

        repeat (2) @(posedge clk);
        #1;
        chk_outputs_clear("reset");
        i_rst_n  = 1'b1;
        i_enable = 1'b1;
        @(posedge clk);
        #1;

        // partial left then partial right: nothing may be emitted before ws 1->0
        repeat (3) slot(1'b0, 1'b1);
        send_word(1'b1, 64'h2AB, 10);
        chk("preamble_dropped", 32'(got_l.size()), 32'd0);

        for (int i = 0; i < 6; i++) begin
            send_word(1'b0, tbl[i].l, tbl[i].nbits);
            send_word(1'b1, tbl[i].r, tbl[i].nbits);
            check_frame($sformatf("tbl%0d", i), tbl[i].exp_l, tbl[i].exp_r);
        end
        chk("no_overrun_streaming", 32'(ovr_cnt), 32'd0);

        // backpressure across two frames
        i_ready = 1'b0;
        ovr0 = ovr_cnt;
        send_word(1'b0, 64'h1111_1111, 32);
        send_word(1'b1, 64'h2222_2222, 32);
        send_word(1'b0, 64'h3333_3333, 32);
        send_word(1'b1, 64'h4444_4444, 32);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_overrun_count", 32'(ovr_cnt - ovr0), 32'd1);
        chk("bp_valid", 32'(o_valid), 32'd1);
        chk("bp_left", o_data_left, 32'h3333_3333);
        chk("bp_right", o_data_right, 32'h4444_4444);

        // ready only in the cycle the next frame loads (tclk sampled at k, load at k+3)
        rv = 64'h6666_6666;
        send_word(1'b0, 64'h5555_5555, 32);
        for (int i = 31; i >= 1; i--)
            slot(1'b1, rv[i]);
        i_ws = 1'b0;
        i_td = rv[0];
        repeat (half) @(posedge clk);
        #1 i_tclk = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
        chk("col_valid", 32'(o_valid), 32'd1);
        chk("col_left", o_data_left, 32'h5555_5555);
        chk("col_right", o_data_right, 32'h6666_6666);
        chk("col_overrun_count", 32'(ovr_cnt - ovr0), 32'd1);
        chk("col_old_accepted", (got_l.size() > 0) ? got_l[0] : 32'hDEAD_BEEF, 32'h3333_3333);
        repeat (half - 1) @(posedge clk);
        #1 i_tclk = 1'b0;
        chk("col_valid_held", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_drops_valid", 32'(o_valid), 32'd0);
        got_l.delete();
        got_r.delete();

        interrupted_frame("midreset", 1'b1);
        interrupted_frame("middisable", 1'b0);

        // randomized widths, data and bit-clock rates against the arithmetic model
        ovr0 = ovr_cnt;
        for (int k = 0; k < 8; k++) begin
            half = $urandom_range(2, 5);
            n    = $urandom_range(8, 40);
            lv   = {$urandom, $urandom};
            rv   = {$urandom, $urandom};
            send_word(1'b0, lv, n);
            send_word(1'b1, rv, n);
            check_frame($sformatf("rand%0d_n%0d", k, n), ref_word(lv, n), ref_word(rv, n));
        end
        chk("rand_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);
        chk("no_extra_frames", 32'(got_l.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
